// File: rtl/point_kinetics_stepper.sv
// Point-kinetics timestep sequencer: strobes the precursor trackers, sums their
// delayed-neutron contributions and integrates the prompt neutron flux.
module point_kinetics_stepper #(
    parameter int unsigned NUM_GROUPS            = 6,
    parameter int unsigned LOG2_STEPS_PER_SECOND = 14,
    parameter int unsigned SETTLE_CYCLES         = 2,
    parameter int unsigned BETA_Q16              = 426,
    parameter int unsigned LOG2_PROMPT_SHIFT     = 16,
    parameter logic [50:0] INIT_FLUX             = 51'h8000_0000_0000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         step_in,
    input  logic signed [15:0]           reactivity_in,
    input  logic [64*NUM_GROUPS-1:0]     precursor_neutrons_in,
    output logic                         new_timestep,
    output logic [50:0]                  neutron_flux,
    output logic                         flux_valid,
    output logic                         busy,
    output logic                         saturated,
    output logic [31:0]                  step_count
);

    localparam int unsigned FLUX_W     = 51;
    localparam int unsigned GRP_DATA_W = 64;
    localparam int unsigned ACC_W      = GRP_DATA_W + ((NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1);
    localparam int unsigned PROD_W     = ((ACC_W + 2) > 72) ? (ACC_W + 2) : 72;
    localparam int unsigned CNT_MAX    = (SETTLE_CYCLES > NUM_GROUPS) ? SETTLE_CYCLES : NUM_GROUPS;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned GRP_IDX_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    localparam logic signed [PROD_W-1:0] BETA_EXT     = PROD_W'(BETA_Q16);
    localparam logic signed [PROD_W-1:0] FLUX_MAX_EXT = PROD_W'({FLUX_W{1'b1}});

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        SETTLE = 3'd2,
        SUM    = 3'd3,
        UPDATE = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      pending_q, pending_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic signed [15:0]        rho_q, rho_d;
    logic [FLUX_W-1:0]         flux_q, flux_d;
    logic                      new_timestep_q, new_timestep_d;
    logic                      flux_valid_q, flux_valid_d;
    logic                      busy_q, busy_d;
    logic                      sat_q, sat_d;
    logic [31:0]               step_count_q, step_count_d;

    logic [GRP_DATA_W-1:0]     groups [NUM_GROUPS];
    logic [ACC_W-1:0]          grp_contrib_c;

    logic signed [PROD_W-1:0]  rho_ext_c;
    logic signed [PROD_W-1:0]  coef_c;
    logic signed [PROD_W-1:0]  flux_ext_c;
    logic signed [PROD_W-1:0]  acc_ext_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [PROD_W-1:0]  delta_c;
    logic signed [PROD_W-1:0]  n_sum_c;
    logic                      clamp_lo_c;
    logic                      clamp_hi_c;
    logic [FLUX_W-1:0]         n_next_c;

    // Unpack the flat precursor bus into one word per tracker group
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_unpack
        assign groups[g] = precursor_neutrons_in[GRP_DATA_W*g +: GRP_DATA_W];
    end

    // Per-step delayed contribution of the group currently being summed
    always_comb begin
        grp_contrib_c = ACC_W'(groups[GRP_IDX_W'(cnt_q)] >> LOG2_STEPS_PER_SECOND);
    end

    // Prompt update n + ((rho - beta) * n >>> shift) + delayed sum, then clamp to the flux range
    always_comb begin
        rho_ext_c  = PROD_W'(rho_q);
        flux_ext_c = PROD_W'(flux_q);
        acc_ext_c  = PROD_W'(acc_q);
        coef_c     = rho_ext_c - BETA_EXT;
        prod_c     = coef_c * flux_ext_c;
        delta_c    = prod_c >>> LOG2_PROMPT_SHIFT;
        n_sum_c    = flux_ext_c + delta_c + acc_ext_c;
        clamp_lo_c = n_sum_c[PROD_W-1];
        clamp_hi_c = !clamp_lo_c && (n_sum_c > FLUX_MAX_EXT);
        if (clamp_lo_c) begin
            n_next_c = '0;
        end else if (clamp_hi_c) begin
            n_next_c = {FLUX_W{1'b1}};
        end else begin
            n_next_c = FLUX_W'(n_sum_c);
        end
    end

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pending_d      = pending_q;
        acc_d          = acc_q;
        rho_d          = rho_q;
        flux_d         = flux_q;
        sat_d          = sat_q;
        step_count_d   = step_count_q;
        flux_valid_d   = 1'b0;

        // A request arriving while a step is in flight is remembered once
        if (state_q != IDLE && step_in) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (step_in || pending_q) begin
                    state_d   = STEP;
                    pending_d = 1'b0;
                end
            end
            STEP: begin
                rho_d   = reactivity_in;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SUM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SUM: begin
                acc_d = acc_q + grp_contrib_c;
                if (cnt_q == CNT_W'(NUM_GROUPS - 1)) begin
                    cnt_d   = '0;
                    state_d = UPDATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UPDATE: begin
                flux_d       = n_next_c;
                flux_valid_d = 1'b1;
                step_count_d = step_count_q + 32'd1;
                if (clamp_lo_c || clamp_hi_c) begin
                    sat_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        new_timestep_d = (state_d == STEP);
        busy_d         = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pending_q      <= 1'b0;
            acc_q          <= '0;
            rho_q          <= '0;
            flux_q         <= INIT_FLUX;
            new_timestep_q <= 1'b0;
            flux_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            sat_q          <= 1'b0;
            step_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            acc_q          <= acc_d;
            rho_q          <= rho_d;
            flux_q         <= flux_d;
            new_timestep_q <= new_timestep_d;
            flux_valid_q   <= flux_valid_d;
            busy_q         <= busy_d;
            sat_q          <= sat_d;
            step_count_q   <= step_count_d;
        end
    end

    assign new_timestep = new_timestep_q;
    assign neutron_flux = flux_q;
    assign flux_valid   = flux_valid_q;
    assign busy         = busy_q;
    assign saturated    = sat_q;
    assign step_count   = step_count_q;

endmodule

// File: tb/tb_point_kinetics_stepper.sv
// Directed and randomized bench for point_kinetics_stepper against an arithmetic flux model.
module tb_point_kinetics_stepper;

    localparam int unsigned NG = 6;
    localparam logic [63:0] INIT_F  = 64'd140737488355328;
    localparam logic [63:0] MAX_F   = 64'd2251799813685247;
    localparam logic [63:0] ONE_STEP_F = 64'd139822660321280;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b0;
    logic                step_in = 1'b0;
    logic signed [15:0]  reactivity_in = '0;
    logic [64*NG-1:0]    precursor = '0;
    logic                new_timestep;
    logic [50:0]         neutron_flux;
    logic                flux_valid;
    logic                busy;
    logic                saturated;
    logic [31:0]         step_count;

    int checks = 0;
    int failures = 0;

    logic [63:0]         grp [NG];
    logic [50:0]         flux_m;
    logic                sat_m;
    logic [31:0]         count_m;
    logic signed [15:0]  rho_v;

    point_kinetics_stepper dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .step_in               (step_in),
        .reactivity_in         (reactivity_in),
        .precursor_neutrons_in (precursor),
        .new_timestep          (new_timestep),
        .neutron_flux          (neutron_flux),
        .flux_valid            (flux_valid),
        .busy                  (busy),
        .saturated             (saturated),
        .step_count            (step_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pack_groups();
        for (int i = 0; i < NG; i++) precursor[64*i +: 64] = grp[i];
    endtask

    // Flux after one step: n + floor((rho - beta) * n / 2^16) + sum(P_i / 2^14), clamped
    function automatic logic [50:0] model_next(input logic [50:0] f, input logic signed [15:0] r,
                                               output logic clamped);
        logic signed [127:0] fv, rv, sum, n, lim;
        fv  = f;
        rv  = r;
        sum = 0;
        lim = (128'sd1 <<< 51) - 128'sd1;
        for (int i = 0; i < NG; i++) sum = sum + 128'(grp[i] >> 14);
        n = fv + (((rv - 128'sd426) * fv) >>> 16) + sum;
        clamped = 1'b0;
        if (n < 0) begin
            clamped = 1'b1;
            return '0;
        end
        if (n > lim) begin
            clamped = 1'b1;
            return 51'(lim);
        end
        return 51'(n);
    endfunction

    task automatic do_reset();
        @(negedge clk_in); rst_in = 1'b1;
        @(negedge clk_in); rst_in = 1'b0;
        flux_m = 51'(INIT_F); sat_m = 1'b0; count_m = '0;
    endtask

    // One isolated step with model prediction, latency and strobe checks
    task automatic run_step(input string tag);
        logic [50:0] exp_f;
        logic        cl;
        int          lat;
        int          nts;
        logic        held;
        exp_f = model_next(flux_m, rho_v, cl);
        reactivity_in = rho_v;
        @(posedge clk_in); #1 step_in = 1'b1;
        @(posedge clk_in); #1 step_in = 1'b0;
        check({tag, "_nts_at_T"}, 64'(new_timestep), 64'd1);
        lat = 0; nts = 0; held = 1'b1;
        while (lat < 40) begin
            if (lat == 2) reactivity_in = 16'($urandom);
            @(posedge clk_in); #1;
            lat++;
            if (new_timestep) nts++;
            if (flux_valid) break;
            if (neutron_flux !== flux_m) held = 1'b0;
        end
        flux_m  = exp_f;
        sat_m   = sat_m | cl;
        count_m = count_m + 32'd1;
        check({tag, "_latency"}, 64'(lat), 64'd10);
        check({tag, "_flux"}, 64'(neutron_flux), 64'(flux_m));
        check({tag, "_flux_held"}, 64'(held), 64'd1);
        check({tag, "_nts_once"}, 64'(nts), 64'd0);
        check({tag, "_count"}, 64'(step_count), 64'(count_m));
        check({tag, "_sat"}, 64'(saturated), 64'(sat_m));
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int n_nts;
        int n_val;
        int nts_t [8];
        logic no_valid;
        logic [50:0] prev;

        for (int i = 0; i < NG; i++) grp[i] = '0;
        pack_groups();
        rho_v = '0;

        // Reset asserted mid-clock takes effect immediately
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check("rst_flux", 64'(neutron_flux), INIT_F);
        check("rst_nts", 64'(new_timestep), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(step_count), 64'd0);
        check("rst_valid", 64'(flux_valid), 64'd0);
        check("rst_sat", 64'(saturated), 64'd0);
        @(negedge clk_in); rst_in = 1'b0;
        flux_m = 51'(INIT_F); sat_m = 1'b0; count_m = '0;

        // Single step with no reactivity and no precursors
        run_step("single");
        check("single_const", 64'(neutron_flux), ONE_STEP_F);

        // Equilibrium: step_in held for exactly five steps
        do_reset();
        grp[0] = 64'd426 << 45;
        pack_groups();
        reactivity_in = '0;
        @(posedge clk_in); #1 step_in = 1'b1;
        cyc = 0; n_nts = 0; n_val = 0;
        while (cyc < 100 && n_val < 5) begin
            @(posedge clk_in); #1;
            cyc++;
            if (new_timestep) begin
                if (n_nts < 8) nts_t[n_nts] = cyc;
                n_nts++;
                if (n_nts == 5) step_in = 1'b0;
            end
            if (flux_valid) begin
                n_val++;
                check("equil_flux", 64'(neutron_flux), INIT_F);
            end
        end
        check("equil_valids", 64'(n_val), 64'd5);
        for (int i = 1; i < 5; i++) check("equil_period", 64'(nts_t[i] - nts_t[i-1]), 64'd11);
        repeat (15) @(posedge clk_in);
        #1;
        check("equil_count", 64'(step_count), 64'd5);
        check("equil_idle", 64'(busy), 64'd0);
        count_m = 32'd5;

        // Pending: a request during the step is queued once, a further one dropped
        @(posedge clk_in); #1 step_in = 1'b1;
        @(posedge clk_in); #1 step_in = 1'b0;
        check("pend_nts0", 64'(new_timestep), 64'd1);
        cyc = 0; n_nts = 0;
        for (int i = 0; i < 8; i++) nts_t[i] = -1;
        while (cyc < 40) begin
            if (cyc == 3) step_in = 1'b1;
            if (cyc == 5) step_in = 1'b0;
            @(posedge clk_in); #1;
            cyc++;
            if (new_timestep) begin
                if (n_nts < 8) nts_t[n_nts] = cyc;
                n_nts++;
            end
        end
        check("pend_extra_steps", 64'(n_nts), 64'd1);
        check("pend_second_T", 64'(nts_t[0]), 64'd11);
        check("pend_count", 64'(step_count), 64'(count_m + 32'd2));
        check("pend_flux", 64'(neutron_flux), INIT_F);
        count_m = count_m + 32'd2;

        // Reset in the middle of SUM aborts the step without a valid pulse
        for (int i = 0; i < NG; i++) grp[i] = 64'd1 << 60;
        pack_groups();
        @(posedge clk_in); #1 step_in = 1'b1;
        @(posedge clk_in); #1 step_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check("midsum_flux", 64'(neutron_flux), INIT_F);
        check("midsum_busy", 64'(busy), 64'd0);
        check("midsum_count", 64'(step_count), 64'd0);
        no_valid = 1'b1;
        repeat (2) begin
            @(posedge clk_in); #1;
            if (flux_valid) no_valid = 1'b0;
        end
        @(negedge clk_in); rst_in = 1'b0;
        repeat (10) begin
            @(posedge clk_in); #1;
            if (flux_valid || busy) no_valid = 1'b0;
        end
        check("midsum_no_valid", 64'(no_valid), 64'd1);
        flux_m = 51'(INIT_F); sat_m = 1'b0; count_m = '0;
        for (int i = 0; i < NG; i++) grp[i] = '0;
        pack_groups();
        rho_v = '0;
        run_step("after_rst");
        check("after_rst_const", 64'(neutron_flux), ONE_STEP_F);

        // Randomized reactivity and precursor loads
        for (int k = 0; k < 6; k++) begin
            rho_v = 16'(16'($urandom_range(0, 4000)) - 16'd2000);
            for (int i = 0; i < NG; i++) grp[i] = 64'($urandom) << $urandom_range(0, 28);
            pack_groups();
            run_step("random");
        end

        // Saturation at the top, then decay with saturated sticky
        for (int i = 0; i < NG; i++) grp[i] = 64'h8000_0000_0000_0000;
        pack_groups();
        rho_v = '0;
        run_step("sat_hi");
        check("sat_hi_const", 64'(neutron_flux), MAX_F);
        check("sat_hi_flag", 64'(saturated), 64'd1);
        for (int i = 0; i < NG; i++) grp[i] = '0;
        pack_groups();
        rho_v = -16'sd32768;
        for (int k = 0; k < 3; k++) begin
            prev = neutron_flux;
            run_step("decay");
            check("decay_lower", 64'(neutron_flux < prev), 64'd1);
            check("decay_sticky", 64'(saturated), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
